// File: rtl/csr_mtrap.sv
// csr_mtrap: machine-mode CSR file with exception, interrupt and MRET sequencing.
// Define MTRAP_VECTORED_EN to enable vectored interrupt dispatch through mtvec[1:0].
module csr_mtrap #(
  parameter logic [31:0] BOOT   = 32'h0000_0000,
  parameter logic [31:0] HARTID = 32'd0,
  parameter int          CNT_W  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [31:0] pc,
  input  logic [31:0] ir,
  input  logic [31:0] rrs1,
  input  logic        irq_timer,
  input  logic        irq_ext,
  output logic [31:0] crslt,
  output logic        trap_taken,
  output logic        mret_taken,
  output logic [31:0] trap_pc,
  output logic [63:0] cycle,
  output logic [63:0] instret
);
  localparam logic [6:0] OP_SYS = 7'b1110011;

  logic             gie_q, gie_d;
  logic             mpie_q, mpie_d;
  logic [1:0]       mie_q, mie_d;
  logic [31:0]      mtvec_q, mtvec_d;
  logic [31:0]      mscratch_q, mscratch_d;
  logic [31:0]      mepc_q, mepc_d;
  logic [31:0]      mcause_q, mcause_d;
  logic [CNT_W-1:0] mcycle_q, mcycle_d;
  logic [CNT_W-1:0] minstret_q, minstret_d;
  logic [31:0]      crslt_q, crslt_d;
  logic [31:0]      trap_pc_q, trap_pc_d;
  logic             trap_taken_q, trap_taken_d;
  logic             mret_taken_q, mret_taken_d;

  logic [63:0] cyc64, ins64;
  logic [31:0] mip, rdata, opnd, wval, base;
  logic [11:0] addr;
  logic [2:0]  f3;
  logic [4:0]  cause;
  logic        ext, tim, intr, sys, priv;
  logic        ecall, ebreak, mret, trap, wen;
  logic        unused_rd;

  assign addr      = ir[31:20];
  assign f3        = ir[14:12];
  assign unused_rd = ^ir[11:7];
  assign cyc64     = 64'(mcycle_q);
  assign ins64     = 64'(minstret_q);
  assign mip       = {20'd0, irq_ext, 3'd0, irq_timer, 7'd0};

  assign ext    = irq_ext & mie_q[1];
  assign tim    = irq_timer & mie_q[0];
  assign intr   = valid & gie_q & (ext | tim);
  assign sys    = valid & (ir[6:0] == OP_SYS) & ~intr;
  assign priv   = sys & (f3 == 3'd0);
  assign ecall  = priv & (ir[21:20] == 2'b00);
  assign ebreak = priv & (ir[21:20] == 2'b01);
  assign mret   = priv & ir[21];
  assign trap   = intr | ecall | ebreak;
  assign opnd   = f3[2] ? {27'd0, ir[19:15]} : rrs1;
  assign wen    = sys & (f3[1:0] != 2'b00)
                & ((f3[1:0] == 2'b01) | (opnd != 32'd0));
  assign cause  = intr ? (ext ? 5'd11 : 5'd7)
                       : (ecall ? 5'd11 : 5'd3);
  assign base   = {mtvec_q[31:2], 2'b00};

  // CSR read mux; always reflects state before this cycle's update
  always_comb begin
    rdata = 32'd0;
    case (addr)
      12'hf14: rdata = HARTID;
      12'h300: rdata = {24'd0, mpie_q, 3'd0, gie_q, 3'd0};
      12'h304: rdata = {20'd0, mie_q[1], 3'd0, mie_q[0], 7'd0};
      12'h305: rdata = mtvec_q;
      12'h340: rdata = mscratch_q;
      12'h341: rdata = mepc_q;
      12'h342: rdata = mcause_q;
      12'h344: rdata = mip;
      12'hb00: rdata = cyc64[31:0];
      12'hb80: rdata = cyc64[63:32];
      12'hb02: rdata = ins64[31:0];
      12'hb82: rdata = ins64[63:32];
      default: rdata = 32'd0;
    endcase
  end

  // Read-modify-write value for the CSR op
  always_comb begin
    wval = rdata;
    unique case (f3[1:0])
      2'b01:   wval = opnd;
      2'b10:   wval = rdata | opnd;
      2'b11:   wval = rdata & ~opnd;
      default: wval = rdata;
    endcase
  end

  // Next state: trap beats MRET beats CSR write
  always_comb begin
    gie_d        = gie_q;
    mpie_d       = mpie_q;
    mie_d        = mie_q;
    mtvec_d      = mtvec_q;
    mscratch_d   = mscratch_q;
    mepc_d       = mepc_q;
    mcause_d     = mcause_q;
    mcycle_d     = mcycle_q + CNT_W'(1);
    minstret_d   = minstret_q + CNT_W'(valid & ~trap);
    crslt_d      = rdata;
    trap_taken_d = trap;
    mret_taken_d = mret;
    trap_pc_d    = 32'd0;
    if (trap) begin
      mepc_d    = pc;
      mcause_d  = {intr, 26'd0, cause};
      mpie_d    = gie_q;
      gie_d     = 1'b0;
      trap_pc_d = base;
`ifdef MTRAP_VECTORED_EN
      if (intr && mtvec_q[1:0] == 2'b01)
        trap_pc_d = base + {25'd0, cause, 2'b00};
`endif
    end else if (mret) begin
      gie_d     = mpie_q;
      mpie_d    = 1'b1;
      trap_pc_d = mepc_q;
    end else if (wen) begin
      case (addr)
        12'h300: begin
          gie_d  = wval[3];
          mpie_d = wval[7];
        end
        12'h304: mie_d = {wval[11], wval[7]};
`ifdef MTRAP_VECTORED_EN
        12'h305: mtvec_d = wval;
`else
        12'h305: mtvec_d = {wval[31:2], 2'b00};
`endif
        12'h340: mscratch_d = wval;
        12'h341: mepc_d     = wval;
        12'h342: mcause_d   = wval;
        default: ;
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      gie_q        <= 1'b0;
      mpie_q       <= 1'b0;
      mie_q        <= 2'b00;
      mtvec_q      <= BOOT;
      mscratch_q   <= 32'd0;
      mepc_q       <= BOOT;
      mcause_q     <= 32'd0;
      mcycle_q     <= '0;
      minstret_q   <= '0;
      crslt_q      <= 32'd0;
      trap_pc_q    <= 32'd0;
      trap_taken_q <= 1'b0;
      mret_taken_q <= 1'b0;
    end else begin
      gie_q        <= gie_d;
      mpie_q       <= mpie_d;
      mie_q        <= mie_d;
      mtvec_q      <= mtvec_d;
      mscratch_q   <= mscratch_d;
      mepc_q       <= mepc_d;
      mcause_q     <= mcause_d;
      mcycle_q     <= mcycle_d;
      minstret_q   <= minstret_d;
      crslt_q      <= crslt_d;
      trap_pc_q    <= trap_pc_d;
      trap_taken_q <= trap_taken_d;
      mret_taken_q <= mret_taken_d;
    end
  end

  assign crslt      = crslt_q;
  assign trap_taken = trap_taken_q;
  assign mret_taken = mret_taken_q;
  assign trap_pc    = trap_pc_q;
  assign cycle      = cyc64;
  assign instret    = ins64;
endmodule

// File: tb/tb_csr_mtrap.sv
// tb_csr_mtrap: directed scenarios plus randomized commits against
// an instruction-level reference model of the machine CSR file.
module tb_csr_mtrap;
  localparam logic [31:0] BOOT = 32'h100;
  localparam logic [31:0] HART = 32'd5;
  localparam int          CW   = 33;
  localparam longint unsigned CMASK = (64'd1 << CW) - 64'd1;

  logic        clk = 1'b0;
  logic        rst, valid, irq_timer, irq_ext;
  logic [31:0] pc, ir, rrs1;
  logic [31:0] crslt, trap_pc;
  logic        trap_taken, mret_taken;
  logic [63:0] cycle, instret;

  int n_pass = 0;
  int n_chk  = 0;

  csr_mtrap #(.BOOT(BOOT), .HARTID(HART), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .valid(valid), .pc(pc), .ir(ir),
    .rrs1(rrs1), .irq_timer(irq_timer), .irq_ext(irq_ext),
    .crslt(crslt), .trap_taken(trap_taken),
    .mret_taken(mret_taken), .trap_pc(trap_pc),
    .cycle(cycle), .instret(instret)
  );

  always #5 clk = ~clk;

  // reference model state
  logic        m_gie, m_mpie, m_meie, m_mtie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
  longint unsigned m_cyc, m_ins;
  logic [31:0] e_crslt, e_tpc;
  logic        e_trap, e_mret;

  function automatic logic [31:0] csr_ir(input logic [11:0] a,
                                         input logic [4:0] s,
                                         input logic [2:0] f);
    return {a, s, f, 5'd1, 7'h73};
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'hf14: return HART;
      12'h300: return (32'(m_gie) << 3) | (32'(m_mpie) << 7);
      12'h304: return (32'(m_meie) << 11) | (32'(m_mtie) << 7);
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return (32'(irq_ext) << 11) | (32'(irq_timer) << 7);
      12'hb00: return 32'(m_cyc);
      12'hb80: return 32'(m_cyc >> 32);
      12'hb02: return 32'(m_ins);
      12'hb82: return 32'(m_ins >> 32);
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_step();
    logic [2:0] f3;
    logic [31:0] op, nv;
    logic ext, tim, intr, sys, ecall, ebreak, mret, trap, wr;
    int cause;
    if (rst) begin
      m_gie = 0; m_mpie = 0; m_meie = 0; m_mtie = 0;
      m_mtvec = BOOT; m_mepc = BOOT; m_mscratch = 0; m_mcause = 0;
      m_cyc = 0; m_ins = 0;
      e_crslt = 0; e_tpc = 0; e_trap = 0; e_mret = 0;
      return;
    end
    e_crslt = m_read(ir[31:20]);
    f3 = ir[14:12];
    ext = irq_ext && m_meie;
    tim = irq_timer && m_mtie;
    intr = valid && m_gie && (ext || tim);
    sys = valid && (ir[6:0] == 7'h73) && !intr;
    ecall  = sys && f3 == 0 && ir[21:20] == 2'd0;
    ebreak = sys && f3 == 0 && ir[21:20] == 2'd1;
    mret   = sys && f3 == 0 && ir[21];
    trap = intr || ecall || ebreak;
    op = f3[2] ? {27'd0, ir[19:15]} : rrs1;
    wr = sys && f3 != 0 && f3 != 4 && (f3[1:0] == 2'd1 || op != 0);
    case (f3[1:0])
      2'd1: nv = op;
      2'd2: nv = e_crslt | op;
      2'd3: nv = e_crslt & ~op;
      default: nv = e_crslt;
    endcase
    e_trap = trap;
    e_mret = mret;
    e_tpc = 0;
    if (trap) begin
      cause = intr ? (ext ? 11 : 7) : (ecall ? 11 : 3);
      e_tpc = m_mtvec & ~32'd3;
`ifdef MTRAP_VECTORED_EN
      if (intr && m_mtvec[1:0] == 2'b01) e_tpc = e_tpc + 32'(4 * cause);
`endif
      m_mcause = {intr, 31'(cause)};
      m_mepc = pc;
      m_mpie = m_gie;
      m_gie = 0;
    end else if (mret) begin
      e_tpc = m_mepc;
      m_gie = m_mpie;
      m_mpie = 1;
    end else if (wr) begin
      case (ir[31:20])
        12'h300: begin m_gie = nv[3]; m_mpie = nv[7]; end
        12'h304: begin m_meie = nv[11]; m_mtie = nv[7]; end
`ifdef MTRAP_VECTORED_EN
        12'h305: m_mtvec = nv;
`else
        12'h305: m_mtvec = nv & ~32'd3;
`endif
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = nv;
        12'h342: m_mcause = nv;
        default: ;
      endcase
    end
    if (valid && !trap) m_ins = (m_ins + 1) & CMASK;
    m_cyc = (m_cyc + 1) & CMASK;
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic idle(input logic [11:0] a);
    valid = 0; ir = csr_ir(a, 5'd0, 3'd0); rrs1 = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle(12'h305); tick();
    n_chk++; if (crslt !== 0 || trap_taken !== 0 || mret_taken !== 0 || trap_pc !== 0 || cycle !== 0 || instret !== 0)
      $display("FAIL reset_outputs crslt=%h tt=%b mt=%b tpc=%h cyc=%0d ins=%0d", crslt, trap_taken, mret_taken, trap_pc, cycle, instret);
    else n_pass++;
    rst = 0; tick();
    n_chk++; if (crslt !== 32'h100) $display("FAIL reset_mtvec got=%h want=00000100", crslt); else n_pass++;
    n_chk++; if (cycle !== 64'd1) $display("FAIL reset_cycle1 got=%0d want=1", cycle); else n_pass++;
    idle(12'h341); tick();
    n_chk++; if (crslt !== 32'h100) $display("FAIL reset_mepc got=%h want=00000100", crslt); else n_pass++;
    idle(12'hf14); tick();
    n_chk++; if (crslt !== HART) $display("FAIL mhartid got=%h want=%h", crslt, HART); else n_pass++;
  endtask

  task automatic test_rw_rc();
    valid = 1; pc = 32'h10; rrs1 = 32'hA5A5_0001; ir = csr_ir(12'h340, 5'd3, 3'd1); tick();
    rrs1 = 1; ir = csr_ir(12'h340, 5'd3, 3'd3); tick();
    n_chk++; if (crslt !== 32'hA5A5_0001) $display("FAIL csrrc_old got=%h want=a5a50001", crslt); else n_pass++;
    rrs1 = 0; ir = csr_ir(12'h340, 5'd0, 3'd2); tick();
    n_chk++; if (crslt !== 32'hA5A5_0000) $display("FAIL csrrs_zero_read got=%h want=a5a50000", crslt); else n_pass++;
    ir = csr_ir(12'h340, 5'h1f, 3'd7); tick();
    idle(12'h340); tick();
    n_chk++; if (crslt !== 32'hA5A5_0000) $display("FAIL csrrci_zimm got=%h want=a5a50000", crslt); else n_pass++;
  endtask

  task automatic test_ecall();
    longint unsigned ins0;
    valid = 1; rrs1 = 32'h400; ir = csr_ir(12'h305, 5'd2, 3'd1); tick();
    rrs1 = 32'h8; ir = csr_ir(12'h300, 5'd2, 3'd1); tick();
    ins0 = m_ins;
    pc = 32'h200; ir = 32'h0000_0073; tick();
    n_chk++; if (trap_taken !== 1 || trap_pc !== 32'h400) $display("FAIL ecall_redirect tt=%b tpc=%h want 1/00000400", trap_taken, trap_pc); else n_pass++;
    n_chk++; if (instret !== ins0) $display("FAIL ecall_instret got=%0d want=%0d", instret, ins0); else n_pass++;
    idle(12'h341); tick();
    n_chk++; if (crslt !== 32'h200 || trap_taken !== 0) $display("FAIL ecall_mepc got=%h tt=%b want=00000200/0", crslt, trap_taken); else n_pass++;
    idle(12'h342); tick();
    n_chk++; if (crslt !== 32'd11) $display("FAIL ecall_mcause got=%h want=0000000b", crslt); else n_pass++;
    idle(12'h300); tick();
    n_chk++; if (crslt !== 32'h80) $display("FAIL ecall_mstatus got=%h want=00000080", crslt); else n_pass++;
  endtask

  task automatic test_mret();
    valid = 1; pc = 32'h404; ir = 32'h3020_0073; tick();
    n_chk++; if (mret_taken !== 1 || trap_pc !== 32'h200 || trap_taken !== 0) $display("FAIL mret_redirect mt=%b tpc=%h want 1/00000200", mret_taken, trap_pc); else n_pass++;
    idle(12'h300); tick();
    n_chk++; if (crslt !== 32'h88 || mret_taken !== 0) $display("FAIL mret_mstatus got=%h mt=%b want=00000088/0", crslt, mret_taken); else n_pass++;
  endtask

  task automatic test_irq();
    logic [31:0] want;
    valid = 1; pc = 32'h20; rrs1 = 32'h880; ir = csr_ir(12'h304, 5'd4, 3'd1); tick();
    rrs1 = 32'h401; ir = csr_ir(12'h305, 5'd4, 3'd1); tick();
    irq_ext = 1; irq_timer = 1; pc = 32'h300;
    rrs1 = 32'hDEAD; ir = csr_ir(12'h340, 5'd4, 3'd1); tick();
`ifdef MTRAP_VECTORED_EN
    want = 32'h42C;
`else
    want = 32'h400;
`endif
    n_chk++; if (trap_taken !== 1 || trap_pc !== want) $display("FAIL irq_redirect tt=%b tpc=%h want 1/%h", trap_taken, trap_pc, want); else n_pass++;
    n_chk++; if (crslt !== 32'hA5A5_0000) $display("FAIL irq_read_old got=%h want=a5a50000", crslt); else n_pass++;
    irq_ext = 0; irq_timer = 0;
    idle(12'h342); tick();
    n_chk++; if (crslt !== 32'h8000_000B) $display("FAIL irq_mcause got=%h want=8000000b", crslt); else n_pass++;
    idle(12'h340); tick();
    n_chk++; if (crslt !== 32'hA5A5_0000) $display("FAIL irq_no_write got=%h want=a5a50000", crslt); else n_pass++;
    idle(12'h341); tick();
    n_chk++; if (crslt !== 32'h300) $display("FAIL irq_mepc got=%h want=00000300", crslt); else n_pass++;
  endtask

  task automatic test_ebreak();
    valid = 1; pc = 32'h500; ir = 32'h0010_0073; tick();
    n_chk++; if (trap_taken !== 1) $display("FAIL ebreak_pulse got=%b want=1", trap_taken); else n_pass++;
    idle(12'h342); tick();
    n_chk++; if (crslt !== 32'd3 || trap_taken !== 0) $display("FAIL ebreak_mcause got=%h tt=%b want=00000003/0", crslt, trap_taken); else n_pass++;
  endtask

  task automatic test_random();
    logic [11:0] addrs [14];
    logic [2:0]  f3s [6];
    int k;
    addrs = '{12'hf14, 12'h301, 12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
              12'h342, 12'h344, 12'hb00, 12'hb80, 12'hb02, 12'hb82, 12'h7c0};
    f3s = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
    for (int i = 0; i < 400; i++) begin
      valid = ($urandom % 4) != 0;
      pc = $urandom & ~32'd3;
      rrs1 = ($urandom % 4 == 0) ? 32'd0 : $urandom;
      irq_ext = ($urandom % 8) == 0;
      irq_timer = ($urandom % 6) == 0;
      k = $urandom % 10;
      if (k < 6)
        ir = csr_ir(addrs[$urandom % 14], 5'($urandom), f3s[$urandom % 6]);
      else if (k == 6) ir = 32'h0000_0073;
      else if (k == 7) ir = 32'h0010_0073;
      else if (k == 8) ir = 32'h3020_0073;
      else ir = {addrs[$urandom % 14], 13'($urandom), 7'h33};
      tick();
      n_chk++; if (crslt !== e_crslt) $display("FAIL rnd%0d_crslt got=%h want=%h", i, crslt, e_crslt); else n_pass++;
      n_chk++; if (trap_taken !== e_trap || mret_taken !== e_mret) $display("FAIL rnd%0d_pulse got=%b%b want=%b%b", i, trap_taken, mret_taken, e_trap, e_mret); else n_pass++;
      n_chk++; if (trap_pc !== e_tpc) $display("FAIL rnd%0d_trap_pc got=%h want=%h", i, trap_pc, e_tpc); else n_pass++;
      n_chk++; if (cycle !== 64'(m_cyc) || instret !== 64'(m_ins)) $display("FAIL rnd%0d_cnt got=%0d/%0d want=%0d/%0d", i, cycle, instret, m_cyc, m_ins); else n_pass++;
    end
    irq_ext = 0; irq_timer = 0;
  endtask

  task automatic test_cnt_wrap();
    idle(12'hb80);
    force dut.mcycle_q = {CW{1'b1}};
    #1;
    release dut.mcycle_q;
    m_cyc = CMASK;
    tick();
    n_chk++; if (cycle !== 64'd0) $display("FAIL wrap_cycle got=%0d want=0", cycle); else n_pass++;
    n_chk++; if (crslt !== 32'd1) $display("FAIL wrap_hi_read got=%h want=00000001", crslt); else n_pass++;
    tick();
    n_chk++; if (crslt !== 32'd0 || cycle !== 64'd1) $display("FAIL wrap_hi_after got=%h cyc=%0d want=0/1", crslt, cycle); else n_pass++;
  endtask

  task automatic test_reset_mid();
    valid = 1; pc = 32'h600; ir = 32'h0000_0073; rst = 1; tick();
    n_chk++; if (trap_taken !== 0 || cycle !== 0 || instret !== 0) $display("FAIL rst_mid tt=%b cyc=%0d ins=%0d want 0/0/0", trap_taken, cycle, instret); else n_pass++;
    rst = 0; idle(12'h341); tick();
    n_chk++; if (crslt !== BOOT || trap_taken !== 0) $display("FAIL rst_mid_mepc got=%h tt=%b want=%h/0", crslt, trap_taken, BOOT); else n_pass++;
  endtask

  initial begin
    rst = 1; valid = 0; pc = 0; ir = 0; rrs1 = 0;
    irq_timer = 0; irq_ext = 0;
    @(negedge clk);
    test_reset();
    test_rw_rc();
    test_ecall();
    test_mret();
    test_irq();
    test_ebreak();
    test_random();
    test_cnt_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
